// File: rtl/debug_mem_loader_pkg.sv
// debug_mem_loader_pkg
//   Shared definitions for the debug memory loader: command opcodes,
//   FSM state encoding, default response codes and small opcode decoders.
package debug_mem_loader_pkg;

  // Command opcodes (first byte of every packet)
  localparam logic [7:0] OP_WR_INST  = 8'h01;
  localparam logic [7:0] OP_WR_DATA  = 8'h02;
  localparam logic [7:0] OP_RD_INST  = 8'h03;
  localparam logic [7:0] OP_RD_DATA  = 8'h04;
  localparam logic [7:0] OP_HOLD_SET = 8'h05;
  localparam logic [7:0] OP_HOLD_CLR = 8'h06;
  // Auto-increment writes; only decoded when DBG_LOADER_AUTOINC_EN is defined
  localparam logic [7:0] OP_AI_INST  = 8'h11;
  localparam logic [7:0] OP_AI_DATA  = 8'h12;

  localparam logic [7:0] ACK_DEFAULT = 8'hA5;
  localparam logic [7:0] ERR_DEFAULT = 8'hEE;

  typedef enum logic [2:0] {
    S_OPC,
    S_ADDR,
    S_DATA,
    S_EXEC,
    S_RWAIT,
    S_RSP
  } loaderState_e;

  function automatic logic isWriteOp(input logic [7:0] op);
    return (op == OP_WR_INST) || (op == OP_WR_DATA) ||
           (op == OP_AI_INST) || (op == OP_AI_DATA);
  endfunction

  function automatic logic isReadOp(input logic [7:0] op);
    return (op == OP_RD_INST) || (op == OP_RD_DATA);
  endfunction

  // 1 = command addresses InstRAM, 0 = DataRAM
  function automatic logic targetsInst(input logic [7:0] op);
    return (op == OP_WR_INST) || (op == OP_RD_INST) || (op == OP_AI_INST);
  endfunction

endpackage

// File: rtl/debug_mem_loader_if.sv
// debug_mem_loader_if
//   Bundles the loader's byte command/response streams and the port-2
//   buses of InstRAM and DataRAM.
//   slave  : loader view (consumes commands, drives RAM port 2)
//   master : host/RAM view (drives commands, supplies read data)
//   cmd_*  : command byte stream (valid/ready/data[8])
//   rsp_*  : response byte stream (valid/ready/data[8])
//   inst_* / data_* : a2[32] byte address, wd2[32], we2[4], rd2[32]
interface debug_mem_loader_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [31:0] inst_a2;
  logic [31:0] inst_wd2;
  logic [3:0]  inst_we2;
  logic [31:0] inst_rd2;
  logic [31:0] data_a2;
  logic [31:0] data_wd2;
  logic [3:0]  data_we2;
  logic [31:0] data_rd2;

  modport slave (
    input  cmd_valid, cmd_data, rsp_ready, inst_rd2, data_rd2,
    output cmd_ready, rsp_valid, rsp_data,
           inst_a2, inst_wd2, inst_we2, data_a2, data_wd2, data_we2
  );

  modport master (
    output cmd_valid, cmd_data, rsp_ready, inst_rd2, data_rd2,
    input  cmd_ready, rsp_valid, rsp_data,
           inst_a2, inst_wd2, inst_we2, data_a2, data_wd2, data_we2
  );
endinterface

// File: rtl/debug_mem_loader_word_assembler.sv
// dbg_word_assembler
//   Collects four bytes, LSB first, into a 32-bit word.
//   clk/rst : clock, synchronous active-high reset
//   load    : restart collection (clears count and partial word)
//   shift   : byteIn is accepted this cycle
//   byteIn  : incoming byte
//   word    : assembled word; complete while done is high
//   done    : this shift delivers the fourth byte
// Only the first three bytes are stored; the fourth is merged
// combinationally so the owner can act on the full word in the same cycle.
module dbg_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        shift,
  input  logic [7:0]  byteIn,
  output logic [31:0] word,
  output logic        done
);
  logic [23:0] shReg;
  logic [1:0]  cnt;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      shReg <= '0;
      cnt   <= '0;
    end else if (shift) begin
      shReg <= {byteIn, shReg[23:8]};
      cnt   <= cnt + 2'd1;   // 3 -> 0 wrap arms the next word
    end
  end

  assign word = {byteIn, shReg};
  assign done = shift && (cnt == 2'd3);
endmodule

// File: rtl/debug_mem_loader.sv
// debug_mem_loader
//   Host-side driver for the core's debug RAM ports. Decodes a byte command
//   stream into word reads/writes on InstRAM/DataRAM port 2 and returns
//   ack/error/read-data bytes on a response stream. Also holds the core in
//   reset (core_hold) while a program is being loaded.
//   Packet: opcode, 4 address bytes LSB first, then 4 data bytes for writes.
// Parameters
//   RD_LATENCY : cycles from a2 valid to rd2 valid (1..3)
//   ACK_CODE   : response byte for completed write/hold commands
//   ERR_CODE   : response byte for illegal opcode or misaligned address
// Ports
//   CPU_CLK   : sole clock
//   CPU_RST   : synchronous active-high reset
//   bus       : command/response streams + RAM port-2 buses (slave view)
//   core_hold : 1 = keep the core in reset
//   busy      : 1 whenever a packet is in progress (FSM not in S_OPC)
// Configuration
//   DBG_LOADER_AUTOINC_EN : adds opcodes 0x11/0x12 (write to last
//   address + 4, data bytes only). Without it those opcodes are illegal
//   and no last-address register exists.
module debug_mem_loader
  import debug_mem_loader_pkg::*;
#(
  parameter int         RD_LATENCY = 1,
  parameter logic [7:0] ACK_CODE   = ACK_DEFAULT,
  parameter logic [7:0] ERR_CODE   = ERR_DEFAULT
) (
  input  logic                CPU_CLK,
  input  logic                CPU_RST,
  debug_mem_loader_if.slave   bus,
  output logic                core_hold,
  output logic                busy
);

  localparam logic [1:0] LAST_WAIT = 2'(RD_LATENCY - 1);

  loaderState_e state;
  logic         started;     // low only in the cycle right after reset
  logic [7:0]   opcode;
  logic [31:0]  curAddr;
  logic         errFlag;
  logic [1:0]   waitCnt;
  logic [1:0]   rspLeft;     // response bytes still to send after rspData
  logic [23:0]  rspShift;
  logic [7:0]   rspData;
  logic         rspValid;
  logic [31:0]  instA2, instWd2, dataA2, dataWd2;
  logic [3:0]   instWe2, dataWe2;

  logic         cmdReady, cmdAccept;
  logic         asmLoad, addrShift, dataShift;
  logic [31:0]  addrWord, dataWord, wrAddr, rdWord;
  logic         addrDone, dataDone;

  assign cmdReady  = started &&
                     ((state == S_OPC) || (state == S_ADDR) || (state == S_DATA));
  assign cmdAccept = bus.cmd_valid && cmdReady;
  assign asmLoad   = cmdAccept && (state == S_OPC);
  assign addrShift = cmdAccept && (state == S_ADDR);
  assign dataShift = cmdAccept && (state == S_DATA);
  assign busy      = (state != S_OPC);

  dbg_word_assembler addrAsm (
    .clk(CPU_CLK), .rst(CPU_RST), .load(asmLoad), .shift(addrShift),
    .byteIn(bus.cmd_data), .word(addrWord), .done(addrDone)
  );

  dbg_word_assembler dataAsm (
    .clk(CPU_CLK), .rst(CPU_RST), .load(asmLoad), .shift(dataShift),
    .byteIn(bus.cmd_data), .word(dataWord), .done(dataDone)
  );

`ifdef DBG_LOADER_AUTOINC_EN
  logic [31:0] lastAddr;
  logic        isAutoInc;
  assign isAutoInc = (opcode == OP_AI_INST) || (opcode == OP_AI_DATA);
  // 32-bit add wraps 0xFFFF_FFFC back to 0
  assign wrAddr    = isAutoInc ? (lastAddr + 32'd4) : curAddr;
`else
  assign wrAddr    = curAddr;
`endif

  assign rdWord = targetsInst(opcode) ? bus.inst_rd2 : bus.data_rd2;

  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      state     <= S_OPC;
      started   <= 1'b0;
      opcode    <= '0;
      curAddr   <= '0;
      errFlag   <= 1'b0;
      waitCnt   <= '0;
      rspLeft   <= '0;
      rspShift  <= '0;
      rspValid  <= 1'b0;
      rspData   <= '0;
      instA2    <= '0;
      instWd2   <= '0;
      instWe2   <= '0;
      dataA2    <= '0;
      dataWd2   <= '0;
      dataWe2   <= '0;
      core_hold <= 1'b1;
`ifdef DBG_LOADER_AUTOINC_EN
      lastAddr  <= '0;
`endif
    end else begin
      started <= 1'b1;
      // write enables are single-cycle pulses; a2/wd2 keep their values
      instWe2 <= '0;
      dataWe2 <= '0;
      case (state)
        S_OPC: begin
          if (cmdAccept) begin
            opcode  <= bus.cmd_data;
            errFlag <= 1'b0;
            case (bus.cmd_data)
              OP_WR_INST, OP_WR_DATA, OP_RD_INST, OP_RD_DATA:
                state <= S_ADDR;
              OP_HOLD_SET, OP_HOLD_CLR: begin
                core_hold <= (bus.cmd_data == OP_HOLD_SET);
                state     <= S_EXEC;
              end
`ifdef DBG_LOADER_AUTOINC_EN
              OP_AI_INST, OP_AI_DATA:
                state <= S_DATA;
`endif
              default: begin
                // unknown opcode: answer at once, consume nothing more
                rspData  <= ERR_CODE;
                rspLeft  <= '0;
                rspValid <= 1'b1;
                state    <= S_RSP;
              end
            endcase
          end
        end

        S_ADDR: begin
          if (addrDone) begin
            curAddr <= addrWord;
`ifdef DBG_LOADER_AUTOINC_EN
            lastAddr <= addrWord;
`endif
            if (isWriteOp(opcode)) begin
              state <= S_DATA;
            end else begin
              errFlag <= (addrWord[1:0] != 2'b00);
              if (addrWord[1:0] == 2'b00) begin
                if (targetsInst(opcode)) instA2 <= addrWord;
                else                     dataA2 <= addrWord;
              end
              state <= S_EXEC;
            end
          end
        end

        S_DATA: begin
          if (dataDone) begin
            errFlag <= (wrAddr[1:0] != 2'b00);
`ifdef DBG_LOADER_AUTOINC_EN
            lastAddr <= wrAddr;
`endif
            // misaligned writes still consume their data bytes but never
            // touch the RAM
            if (wrAddr[1:0] == 2'b00) begin
              if (targetsInst(opcode)) begin
                instA2  <= wrAddr;
                instWd2 <= dataWord;
                instWe2 <= 4'hF;
              end else begin
                dataA2  <= wrAddr;
                dataWd2 <= dataWord;
                dataWe2 <= 4'hF;
              end
            end
            state <= S_EXEC;
          end
        end

        S_EXEC: begin
          if (isReadOp(opcode) && !errFlag) begin
            waitCnt <= '0;
            state   <= S_RWAIT;
          end else begin
            rspData  <= errFlag ? ERR_CODE : ACK_CODE;
            rspLeft  <= '0;
            rspValid <= 1'b1;
            state    <= S_RSP;
          end
        end

        S_RWAIT: begin
          if (waitCnt == LAST_WAIT) begin
            {rspShift, rspData} <= rdWord;
            rspLeft  <= 2'd3;
            rspValid <= 1'b1;
            state    <= S_RSP;
          end else begin
            waitCnt <= waitCnt + 2'd1;
          end
        end

        S_RSP: begin
          if (bus.rsp_ready) begin
            if (rspLeft == 2'd0) begin
              rspValid <= 1'b0;
              state    <= S_OPC;
            end else begin
              rspData  <= rspShift[7:0];
              rspShift <= {8'h00, rspShift[23:8]};
              rspLeft  <= rspLeft - 2'd1;
            end
          end
        end

        default: state <= S_OPC;
      endcase
    end
  end

  assign bus.cmd_ready = cmdReady;
  assign bus.rsp_valid = rspValid;
  assign bus.rsp_data  = rspData;
  assign bus.inst_a2   = instA2;
  assign bus.inst_wd2  = instWd2;
  assign bus.inst_we2  = instWe2;
  assign bus.data_a2   = dataA2;
  assign bus.data_wd2  = dataWd2;
  assign bus.data_we2  = dataWe2;

endmodule

// File: tb/tb_debug_mem_loader.sv
// tb_debug_mem_loader
//   Scoreboarded bench: expected response bytes are queued as commands are
//   driven and popped as the loader emits them. Small RAM models sit on
//   both port-2 buses with one cycle of read latency.
module tb_debug_mem_loader;
  logic CPU_CLK = 1'b0;
  logic CPU_RST;
  logic core_hold, busy;

  debug_mem_loader_if bus();

  debug_mem_loader #(.RD_LATENCY(1)) dut (
    .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST), .bus(bus),
    .core_hold(core_hold), .busy(busy)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int expQ[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // RAM models; DataRAM word 0x20 is preloaded while reset is held
  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  always @(posedge CPU_CLK) begin
    if (CPU_RST) dmem[8] <= 32'h12345678;
    else begin
      if (bus.inst_we2 == 4'hF) imem[bus.inst_a2[9:2]] <= bus.inst_wd2;
      if (bus.data_we2 == 4'hF) dmem[bus.data_a2[9:2]] <= bus.data_wd2;
    end
    bus.inst_rd2 <= imem[bus.inst_a2[9:2]];
    bus.data_rd2 <= dmem[bus.data_a2[9:2]];
  end

  always @(posedge CPU_CLK) cyc <= cyc + 1;

  // Bus monitor: write-enable pulses and response scoreboard
  int          instWeCyc = 0, dataWeCyc = 0, riseCyc = 0;
  logic [31:0] lastIA2 = '0, lastIWd2 = '0, lastDA2 = '0, lastDWd2 = '0;
  logic        prevValid = 1'b0;
  initial begin
    int e;
    forever begin
      @(negedge CPU_CLK);
      if (bus.inst_we2 != 4'h0) begin
        instWeCyc++; lastIA2 = bus.inst_a2; lastIWd2 = bus.inst_wd2;
      end
      if (bus.data_we2 != 4'h0) begin
        dataWeCyc++; lastDA2 = bus.data_a2; lastDWd2 = bus.data_wd2;
      end
      if (bus.rsp_valid && !prevValid) riseCyc = cyc;
      if (bus.rsp_valid && bus.rsp_ready) begin
        e = (expQ.size() != 0) ? expQ.pop_front() : 32'h100;
        chk("rspByte", {24'h0, bus.rsp_data}, e);
      end
      prevValid = bus.rsp_valid;
    end
  end

  logic toggleRdy = 1'b0;
  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge CPU_CLK); #1;
      bus.rsp_ready = toggleRdy ? ~bus.rsp_ready : 1'b1;
    end
  end

  int lastAccCyc = 0;

  task automatic sendByte(input logic [7:0] b);
    int   n = 0;
    logic got = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = b;
    while (!got && n < 200) begin
      @(negedge CPU_CLK);
      if (bus.cmd_ready) begin got = 1'b1; lastAccCyc = cyc; end
      n++;
    end
    if (!got) chk("cmdTimeout", {31'h0, bus.cmd_ready}, 32'h1);
    @(posedge CPU_CLK); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w);
    for (int i = 0; i < 4; i++) sendByte(w[8*i +: 8]);
  endtask

  task automatic waitIdle();
    int n = 0;
    do begin
      @(negedge CPU_CLK);
      n++;
    end while ((expQ.size() != 0 || busy || bus.rsp_valid) && n < 500);
    chk("drainQ", expQ.size(), 0);
    @(posedge CPU_CLK); #1;
  endtask

  task automatic pushWord(input logic [31:0] w);
    for (int i = 0; i < 4; i++) expQ.push_back(int'(w[8*i +: 8]));
  endtask

  initial begin
    int acc;
    CPU_RST = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'h00;
    repeat (3) @(posedge CPU_CLK);
    @(negedge CPU_CLK);
    chk("rstCmdReady", {31'h0, bus.cmd_ready}, 0);
    chk("rstRspValid", {31'h0, bus.rsp_valid}, 0);
    chk("rstRspData",  {24'h0, bus.rsp_data}, 0);
    chk("rstInstA2",   bus.inst_a2, 0);
    chk("rstDataWd2",  bus.data_wd2, 0);
    chk("rstWe2",      {24'h0, bus.inst_we2, bus.data_we2}, 0);
    chk("rstHold",     {31'h0, core_hold}, 1);
    chk("rstBusy",     {31'h0, busy}, 0);
    @(posedge CPU_CLK); #1;
    CPU_RST = 1'b0;
    repeat (2) @(negedge CPU_CLK);
    chk("readyAfterRst", {31'h0, bus.cmd_ready}, 1);
    @(posedge CPU_CLK); #1;

    // InstRAM write
    expQ.push_back(8'hA5);
    sendByte(8'h01); sendWord(32'h0000_1000); sendWord(32'hDEAD_BEEF);
    acc = lastAccCyc;
    waitIdle();
    chk("wrLat",     riseCyc - acc, 2);
    chk("instWeCyc", instWeCyc, 1);
    chk("dataWeCyc", dataWeCyc, 0);
    chk("instA2",    lastIA2, 32'h0000_1000);
    chk("instWd2",   lastIWd2, 32'hDEAD_BEEF);
    chk("a2Retain",  bus.inst_a2, 32'h0000_1000);
    chk("weIdle",    {28'h0, bus.inst_we2}, 0);

    // InstRAM read-back
    pushWord(32'hDEAD_BEEF);
    sendByte(8'h03); sendWord(32'h0000_1000);
    acc = lastAccCyc;
    waitIdle();
    chk("rdLatInst", riseCyc - acc, 3);

    // DataRAM preload read with response backpressure
    toggleRdy = 1'b1;
    pushWord(32'h1234_5678);
    sendByte(8'h04); sendWord(32'h0000_0020);
    acc = lastAccCyc;
    waitIdle();
    chk("rdLatData", riseCyc - acc, 3);
    toggleRdy = 1'b0;

    // DataRAM write + read-back
    expQ.push_back(8'hA5);
    sendByte(8'h02); sendWord(32'h0000_0008); sendWord(32'hCAFE_F00D);
    waitIdle();
    chk("dataWeCyc1", dataWeCyc, 1);
    chk("instWeCyc1", instWeCyc, 1);
    chk("dataA2",     lastDA2, 32'h0000_0008);
    chk("dataWd2",    lastDWd2, 32'hCAFE_F00D);
    pushWord(32'hCAFE_F00D);
    sendByte(8'h04); sendWord(32'h0000_0008);
    waitIdle();

    // misaligned write and read
    expQ.push_back(8'hEE);
    sendByte(8'h02); sendWord(32'h0000_0002); sendWord(32'h1122_3344);
    waitIdle();
    chk("misWrNoWe", dataWeCyc, 1);
    expQ.push_back(8'hEE);
    sendByte(8'h03); sendWord(32'h0000_1001);
    waitIdle();
    chk("misRdA2", bus.inst_a2, 32'h0000_1000);

    // illegal opcode; next byte is a fresh opcode
    expQ.push_back(8'hEE);
    expQ.push_back(8'hA5);
    sendByte(8'h7F); sendByte(8'h06);
    waitIdle();
    chk("holdClr", {31'h0, core_hold}, 0);

    // reset in the middle of a packet
    sendByte(8'h01); sendByte(8'h00); sendByte(8'h02);
    CPU_RST = 1'b1;
    @(posedge CPU_CLK); #1;
    CPU_RST = 1'b0;
    @(negedge CPU_CLK);
    chk("midRstBusy",  {31'h0, busy}, 0);
    chk("midRstHold",  {31'h0, core_hold}, 1);
    chk("midRstReady", {31'h0, bus.cmd_ready}, 0);
    @(posedge CPU_CLK); #1;
    chk("midRstNoWe", instWeCyc, 1);
    expQ.push_back(8'hA5);
    sendByte(8'h01); sendWord(32'h0000_0040); sendWord(32'h0BAD_F00D);
    waitIdle();
    chk("freshWeCyc", instWeCyc, 2);
    chk("freshA2",    lastIA2, 32'h0000_0040);
    chk("freshWd2",   lastIWd2, 32'h0BAD_F00D);

    // hold clear then set
    expQ.push_back(8'hA5);
    sendByte(8'h06);
    waitIdle();
    chk("holdClr2", {31'h0, core_hold}, 0);
    expQ.push_back(8'hA5);
    sendByte(8'h05);
    waitIdle();
    chk("holdSet", {31'h0, core_hold}, 1);

`ifdef DBG_LOADER_AUTOINC_EN
    expQ.push_back(8'hA5);
    sendByte(8'h01); sendWord(32'h0000_0000); sendWord(32'h1111_1111);
    waitIdle();
    expQ.push_back(8'hA5);
    sendByte(8'h11); sendWord(32'h2222_2222);
    waitIdle();
    chk("aiWeCyc", instWeCyc, 4);
    chk("aiA2",    lastIA2, 32'h0000_0004);
    chk("aiWd2",   lastIWd2, 32'h2222_2222);
`else
    expQ.push_back(8'hEE);
    expQ.push_back(8'hA5);
    sendByte(8'h11); sendByte(8'h05);
    waitIdle();
    chk("aiIllegalNoWe", instWeCyc, 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end
endmodule
